stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 142 ++++++++++++++
 tb/tb_stage_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: walks each instruction through
// fetch/decode/execute/memory/writeback and owns pc and the retired count.
module stage_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic        branch,
  input  logic        alu_bit0,
  input  logic [63:0] imm,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        regwrite,
  input  logic        memtoreg,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [2:0]  stage,
  output logic        ir_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rf_we,
  output logic        rf_wsel,
  output logic        halted,
  output logic        error,
  output logic [31:0] retired
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [6:0]  HALT_OP = 7'b1111111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             lat_branch;
  logic             lat_memread;
  logic             lat_memwrite;
  logic             lat_regwrite;
  logic             lat_memtoreg;
  logic             taken;
  logic [31:0]      branch_off;
  logic             unused_imm;

  // Only imm[30:0] contributes to the branch offset.
  assign branch_off = {imm[30:0], 1'b0};
  assign unused_imm = ^imm[63:31];
  assign stage      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:      if (start) next_state = S_FETCH;
      S_FETCH:     next_state = S_DECODE;
      S_DECODE:    next_state = (opcode == HALT_OP) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   next_state = (lat_memread || lat_memwrite) ? S_MEMORY : S_WRITEBACK;
      // A late mem_ready on the final allowed cycle still completes the access.
      S_MEMORY: begin
        if (mem_ready)                  next_state = S_WRITEBACK;
        else if (wait_cnt == CNT_LAST)  next_state = S_ERROR;
      end
      S_WRITEBACK: next_state = S_FETCH;
      S_HALT:      next_state = S_HALT;
      S_ERROR:     next_state = S_ERROR;
      default:     next_state = S_IDLE;
    endcase
  end

  // Strobes and status are registered from the upcoming state so they line up with stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_en   <= 1'b0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      rf_we   <= 1'b0;
      rf_wsel <= 1'b0;
      halted  <= 1'b0;
      error   <= 1'b0;
    end else begin
      ir_en   <= (next_state == S_FETCH);
      mem_req <= (next_state == S_MEMORY);
      mem_we  <= (next_state == S_MEMORY) && lat_memwrite;
      rf_we   <= (next_state == S_WRITEBACK) && (lat_regwrite || lat_memtoreg);
      rf_wsel <= (next_state == S_WRITEBACK) && lat_memtoreg;
      halted  <= (next_state == S_HALT);
      error   <= (next_state == S_ERROR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_branch   <= 1'b0;
      lat_memread  <= 1'b0;
      lat_memwrite <= 1'b0;
      lat_regwrite <= 1'b0;
      lat_memtoreg <= 1'b0;
      taken        <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      if (state == S_DECODE && opcode != HALT_OP) begin
        lat_branch   <= branch;
        lat_memread  <= memread;
        lat_memwrite <= memwrite;
        lat_regwrite <= regwrite;
        lat_memtoreg <= memtoreg;
      end
      if (state == S_EXECUTE) taken <= lat_branch & alu_bit0;
      if (state != S_MEMORY)  wait_cnt <= '0;
      else if (!mem_ready)    wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Architectural state advances only when an instruction leaves writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      retired <= '0;
    end else if (state == S_WRITEBACK) begin
      pc <= taken ? (pc + branch_off) : (pc + 32'd4);
      if (retired != 32'hFFFF_FFFF) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench: scenarios expand into per-cycle stimulus/expectation records
// from the stage rules; one process compares every cycle.
module tb_stage_sequencer;

  localparam int unsigned T_OUT = 15;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6, ST_ERR = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  opcode = '0;
  logic        branch = 1'b0, alu_bit0 = 1'b0;
  logic [63:0] imm = '0;
  logic        memread = 1'b0, memwrite = 1'b0, regwrite = 1'b0, memtoreg = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] pc, retired;
  logic [2:0]  stage;
  logic        ir_en, mem_req, mem_we, rf_we, rf_wsel, halted, error;

  always #5 clk = ~clk;

  stage_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .branch(branch),
    .alu_bit0(alu_bit0), .imm(imm), .memread(memread), .memwrite(memwrite),
    .regwrite(regwrite), .memtoreg(memtoreg), .mem_ready(mem_ready),
    .pc(pc), .stage(stage), .ir_en(ir_en), .mem_req(mem_req), .mem_we(mem_we),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .halted(halted), .error(error), .retired(retired)
  );

  typedef struct {
    logic        rst_n, start;
    logic [6:0]  opcode;
    logic        branch, alu_bit0;
    logic [63:0] imm;
    logic        memread, memwrite, regwrite, memtoreg, mem_ready;
    logic [2:0]  stage;
    logic        ir_en, mem_req, mem_we, rf_we, rf_wsel, halted, error;
    logic [31:0] pc, retired;
  } cyc_t;

  cyc_t q[$];
  cyc_t cur;
  bit   cur_valid = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Architectural model and the decoder fields of the instruction being generated.
  logic [31:0] m_pc, m_retired;
  logic        m_halt, m_err;
  logic        f_start, f_branch, f_alu, f_rd, f_wr, f_rw, f_m2r;
  logic [6:0]  f_op;
  logic [63:0] f_imm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      chk("stage",   32'(stage),   32'(cur.stage));
      chk("ir_en",   32'(ir_en),   32'(cur.ir_en));
      chk("mem_req", 32'(mem_req), 32'(cur.mem_req));
      chk("mem_we",  32'(mem_we),  32'(cur.mem_we));
      chk("rf_we",   32'(rf_we),   32'(cur.rf_we));
      chk("rf_wsel", 32'(rf_wsel), 32'(cur.rf_wsel));
      chk("halted",  32'(halted),  32'(cur.halted));
      chk("error",   32'(error),   32'(cur.error));
      chk("pc",      pc,           cur.pc);
      chk("retired", retired,      cur.retired);
    end
  end

  task automatic push(input logic rst, input logic rdy, input logic [2:0] st, input logic ir,
                      input logic mq, input logic mw, input logic rw, input logic rs);
    cyc_t r;
    r.rst_n = rst;       r.start = f_start;   r.opcode = f_op;      r.branch = f_branch;
    r.alu_bit0 = f_alu;  r.imm = f_imm;       r.memread = f_rd;     r.memwrite = f_wr;
    r.regwrite = f_rw;   r.memtoreg = f_m2r;  r.mem_ready = rdy;
    r.stage = st;        r.ir_en = ir;        r.mem_req = mq;       r.mem_we = mw;
    r.rf_we = rw;        r.rf_wsel = rs;      r.halted = m_halt;    r.error = m_err;
    r.pc = m_pc;         r.retired = m_retired;
    q.push_back(r);
  endtask

  task automatic do_reset();
    m_pc = 32'h0; m_retired = 32'h0; m_halt = 1'b0; m_err = 1'b0;
    f_start = 1'b0; f_op = '0; f_branch = 0; f_alu = 0; f_imm = '0;
    f_rd = 0; f_wr = 0; f_rw = 0; f_m2r = 0;
    push(1'b0, 1'b0, ST_IDLE, 0, 0, 0, 0, 0);
    push(1'b1, 1'b0, ST_IDLE, 0, 0, 0, 0, 0);
    push(1'b1, 1'b0, ST_IDLE, 0, 0, 0, 0, 0);
  endtask

  task automatic do_start();
    f_start = 1'b1;
    push(1'b1, 1'b0, ST_IDLE, 0, 0, 0, 0, 0);
  endtask

  // zeros: cycles of mem_ready=0 before it rises; abort_mem>=0 stops after that many memory cycles.
  task automatic instr(input logic [6:0] op, input logic br, input logic alu, input logic [63:0] im,
                       input logic rd, input logic wr, input logic rw, input logic m2r,
                       input int zeros, input int abort_mem);
    int n;
    f_op = op; f_branch = br; f_alu = alu; f_imm = im;
    f_rd = rd; f_wr = wr; f_rw = rw; f_m2r = m2r; f_start = 1'b1;
    push(1'b1, 1'b0, ST_FETCH, 1, 0, 0, 0, 0);
    push(1'b1, 1'b0, ST_DECODE, 0, 0, 0, 0, 0);
    if (op == 7'h7F) begin
      m_halt = 1'b1;
      for (int k = 0; k < 6; k++) push(1'b1, 1'b0, ST_HALT, 0, 0, 0, 0, 0);
      return;
    end
    push(1'b1, 1'b0, ST_EXEC, 0, 0, 0, 0, 0);
    if (rd || wr) begin
      n = (zeros < int'(T_OUT)) ? zeros + 1 : int'(T_OUT);
      for (int k = 0; k < n; k++) begin
        if (k == abort_mem) return;
        push(1'b1, (k == zeros), ST_MEM, 0, 1, wr, 0, 0);
      end
      if (zeros >= int'(T_OUT)) begin
        m_err = 1'b1;
        for (int k = 0; k < 4; k++) push(1'b1, 1'b0, ST_ERR, 0, 0, 0, 0, 0);
        return;
      end
    end
    push(1'b1, 1'b0, ST_WB, 0, 0, 0, rw | m2r, m2r);
    m_pc = (br && alu) ? m_pc + (32'(im[30:0]) << 1) : m_pc + 32'd4;
    if (m_retired != 32'hFFFF_FFFF) m_retired = m_retired + 32'd1;
  endtask

  task automatic alu_op();
    instr(7'h33, 0, 0, 64'h0, 0, 0, 1, 0, 0, -1);
  endtask

  task automatic tail();
    push(1'b1, 1'b0, ST_FETCH, 1, 0, 0, 0, 0);
  endtask

  task automatic drain();
    while (q.size() > 0) begin
      @(posedge clk); #1;
      cur = q.pop_front();
      rst_n = cur.rst_n;     start = cur.start;       opcode = cur.opcode;
      branch = cur.branch;   alu_bit0 = cur.alu_bit0; imm = cur.imm;
      memread = cur.memread; memwrite = cur.memwrite; regwrite = cur.regwrite;
      memtoreg = cur.memtoreg; mem_ready = cur.mem_ready;
      cur_valid = 1'b1;
    end
    @(negedge clk); #1;
    cur_valid = 1'b0;
  endtask

  initial begin
    // ALU then store, zero-wait memory.
    do_reset(); do_start(); alu_op();
    chk("model_alu_pc", m_pc, 32'h4);
    instr(7'h23, 0, 0, 64'h0, 0, 1, 0, 0, 0, -1);
    tail(); drain();
    chk("alu_store_pc", pc, 32'h8);
    chk("alu_store_retired", retired, 32'd2);

    // Load with three wait cycles: memory data selected in writeback.
    do_reset(); do_start();
    instr(7'h03, 0, 0, 64'h0, 1, 0, 0, 1, 3, -1);
    tail(); drain();
    chk("load_pc", pc, 32'h4);

    // Taken branch from 0x10.
    do_reset(); do_start();
    for (int i = 0; i < 4; i++) alu_op();
    chk("model_pc_before_branch", m_pc, 32'h10);
    instr(7'h63, 1, 1, 64'h8, 0, 0, 0, 0, 0, -1);
    tail(); drain();
    chk("branch_taken_pc", pc, 32'h20);
    chk("branch_taken_retired", retired, 32'd5);

    // Not-taken branch, then a wrapping offset and an immediate with high bits set.
    do_reset(); do_start();
    for (int i = 0; i < 4; i++) alu_op();
    instr(7'h63, 1, 0, 64'h8, 0, 0, 0, 0, 0, -1);
    chk("model_not_taken_pc", m_pc, 32'h14);
    instr(7'h63, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, -1);
    chk("model_wrap_pc", m_pc, 32'h12);
    instr(7'h63, 1, 1, 64'hFFFF_FFFF_8000_0004, 0, 0, 0, 0, 0, -1);
    tail(); drain();
    chk("imm_high_bits_pc", pc, 32'h1A);

    // Halt: sticky, start ignored, only reset recovers.
    do_reset(); do_start(); alu_op();
    instr(7'h7F, 0, 0, 64'h0, 0, 0, 0, 0, 0, -1);
    drain();
    chk("halt_stage", 32'(stage), 32'd6);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", pc, 32'h4);
    do_reset(); drain();
    chk("halt_cleared", 32'(halted), 32'd0);

    // Memory timeout into ERROR.
    do_reset(); do_start();
    instr(7'h23, 0, 0, 64'h0, 0, 1, 0, 0, 1000, -1);
    drain();
    chk("timeout_stage", 32'(stage), 32'd7);
    chk("timeout_error", 32'(error), 32'd1);

    // mem_ready on the last allowed cycle wins over timeout.
    do_reset(); do_start();
    instr(7'h23, 0, 0, 64'h0, 0, 1, 0, 0, int'(T_OUT) - 1, -1);
    tail(); drain();
    chk("late_ready_pc", pc, 32'h4);
    chk("late_ready_error", 32'(error), 32'd0);

    // Reset in the middle of a memory access.
    do_reset(); do_start(); alu_op();
    instr(7'h03, 0, 0, 64'h0, 1, 0, 1, 1, 1000, 3);
    do_reset(); drain();
    chk("abort_pc", pc, 32'h0);
    chk("abort_retired", retired, 32'd0);
    chk("abort_mem_req", 32'(mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
